// File: rtl/wisc_pkg.sv
// Shared WISC ISA constants and the fetch-stage state type.
package wisc_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  localparam logic [3:0]  OP_HLT           = 4'hF;
  localparam int          ILEN_BYTES       = 2;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load, hold, bubble (clear valid+instr) and kill (clear valid only).
module ifid_reg #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic              kill,
  input  logic [DWIDTH-1:0] instr_in,
  input  logic [AWIDTH-1:0] pc_in,
  input  logic [AWIDTH-1:0] pc_plus2_in,
  output logic              valid,
  output logic [DWIDTH-1:0] instr,
  output logic [AWIDTH-1:0] pc,
  output logic [AWIDTH-1:0] pc_plus2
);

  // bubble > load > kill > hold; pc fields are left alone on bubble/kill
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= '0;
      pc       <= '0;
      pc_plus2 <= '0;
    end else if (bubble) begin
      valid <= 1'b0;
      instr <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= instr_in;
      pc       <= pc_in;
      pc_plus2 <= pc_plus2_in;
    end else if (kill) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: owns the PC, drives the single-cycle imem and fills IF/ID.
// Handshake: no valid/ready; stall holds everything, redirect_valid is a one-cycle command that beats stall.
module fetch_stage
  import wisc_pkg::*;
#(
  parameter int              DWIDTH     = 16,
  parameter int              AWIDTH     = 16,
  parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(DEFAULT_RESET_PC),
  parameter logic [3:0]      HLT_OPCODE = OP_HLT
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] imem_addr,
  output logic              imem_enable,
  output logic              imem_wr,
  output logic [DWIDTH-1:0] imem_wdata,
  input  logic [DWIDTH-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              ifid_valid,
  output logic [DWIDTH-1:0] ifid_instr,
  output logic [AWIDTH-1:0] ifid_pc,
  output logic [AWIDTH-1:0] ifid_pc_plus2,
  output logic              halted,
  output logic [15:0]       fetch_count,
  output fetch_state_t      state_dbg
);

  fetch_state_t      state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d, pc_plus2;
  logic [15:0]       fetch_count_q, fetch_count_d;
  logic              ld_ifid, bubble_ifid, kill_ifid, is_hlt;
  logic              unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[0];
  assign pc_plus2 = pc_q + AWIDTH'(ILEN_BYTES);
  assign is_hlt   = (imem_rdata[DWIDTH-1 -: 4] == HLT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    ld_ifid       = 1'b0;
    bubble_ifid   = 1'b0;
    kill_ifid     = 1'b0;
    if (redirect_valid) begin
      pc_d        = {redirect_pc[AWIDTH-1:1], 1'b0};
      state_d     = ST_RUN;
      bubble_ifid = 1'b1;
    end else if (!stall) begin
      case (state_q)
        ST_RUN: begin
          ld_ifid = 1'b1;
          if (fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
          // HLT parks the PC on itself so a later redirect is the only way out
          if (is_hlt) state_d = ST_HALTED;
          else        pc_d    = pc_plus2;
        end
        ST_HALTED: kill_ifid = 1'b1;
        default:   state_d   = ST_RUN;
      endcase
    end
  end

  ifid_reg #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_ifid (
    .clk         (clk),
    .rst         (rst),
    .load        (ld_ifid),
    .bubble      (bubble_ifid),
    .kill        (kill_ifid),
    .instr_in    (imem_rdata),
    .pc_in       (pc_q),
    .pc_plus2_in (pc_plus2),
    .valid       (ifid_valid),
    .instr       (ifid_instr),
    .pc          (ifid_pc),
    .pc_plus2    (ifid_pc_plus2)
  );

  assign imem_addr   = pc_q;
  assign imem_enable = (state_q == ST_RUN) && !rst;
  assign imem_wr     = 1'b0;
  assign imem_wdata  = '0;
  assign halted      = (state_q == ST_HALTED);
  assign fetch_count = fetch_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction-memory model.
module tb_fetch_stage;
  import wisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_enable;
  logic        imem_wr;
  logic [15:0] imem_wdata;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_plus2;
  logic        halted;
  logic [15:0] fetch_count;
  fetch_state_t state_dbg;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [15:0] mem [0:32767];

  // clock/reset block
  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[15:1]];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_enable    (imem_enable),
    .imem_wr        (imem_wr),
    .imem_wdata     (imem_wdata),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus2  (ifid_pc_plus2),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .state_dbg      (state_dbg)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [15:0] ins,
                            input logic [15:0] pc, input logic [15:0] pc2);
    check({tag, ".valid"}, 16'(ifid_valid), 16'(v));
    check({tag, ".instr"}, ifid_instr, ins);
    check({tag, ".pc"}, ifid_pc, pc);
    check({tag, ".pc2"}, ifid_pc_plus2, pc2);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[16'h0000 >> 1] = 16'h1234;
    mem[16'h0002 >> 1] = 16'h5678;
    mem[16'h0004 >> 1] = 16'h9ABC;
    mem[16'h0006 >> 1] = 16'hF000;
    mem[16'h0010 >> 1] = 16'h2222;
    mem[16'h0030 >> 1] = 16'h4444;
    mem[16'hFFFE >> 1] = 16'h3333;

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    step();
    step();
    check_ifid("rst", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    check("rst.count", fetch_count, 16'h0000);
    check("rst.halted", 16'(halted), 16'h0000);
    check("rst.en", 16'(imem_enable), 16'h0000);
    check("rst.wr", 16'(imem_wr), 16'h0000);
    check("rst.wdata", imem_wdata, 16'h0000);

    rst = 1'b0;
    #1;
    check("run.en", 16'(imem_enable), 16'h0001);
    check("run.addr0", imem_addr, 16'h0000);
    step();
    check_ifid("f0", 1'b1, 16'h1234, 16'h0000, 16'h0002);
    step();
    check_ifid("f1", 1'b1, 16'h5678, 16'h0002, 16'h0004);
    check("f1.count", fetch_count, 16'd2);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("stall", 1'b1, 16'h5678, 16'h0002, 16'h0004);
      check("stall.addr", imem_addr, 16'h0004);
      check("stall.count", fetch_count, 16'd2);
    end
    stall = 1'b0;
    step();
    check_ifid("f2", 1'b1, 16'h9ABC, 16'h0004, 16'h0006);
    check("f2.count", fetch_count, 16'd3);

    step();
    check_ifid("hlt", 1'b1, 16'hF000, 16'h0006, 16'h0008);
    check("hlt.halted", 16'(halted), 16'h0001);
    check("hlt.state", 16'(state_dbg), 16'(ST_HALTED));
    check("hlt.en", 16'(imem_enable), 16'h0000);
    check("hlt.addr", imem_addr, 16'h0006);
    check("hlt.count", fetch_count, 16'd4);
    for (int i = 0; i < 2; i++) begin
      step();
      check("halt.valid", 16'(ifid_valid), 16'h0000);
      check("halt.addr", imem_addr, 16'h0006);
      check("halt.count", fetch_count, 16'd4);
      check("halt.halted", 16'(halted), 16'h0001);
    end

    redirect_valid = 1'b1; redirect_pc = 16'h0011; stall = 1'b1;
    step();
    check("hredir.halted", 16'(halted), 16'h0000);
    check("hredir.addr", imem_addr, 16'h0010);
    check("hredir.en", 16'(imem_enable), 16'h0001);
    check("hredir.valid", 16'(ifid_valid), 16'h0000);
    check("hredir.instr", ifid_instr, 16'h0000);
    redirect_valid = 1'b0; stall = 1'b0;
    step();
    check_ifid("f10", 1'b1, 16'h2222, 16'h0010, 16'h0012);
    check("f10.count", fetch_count, 16'd5);

    redirect_valid = 1'b1; redirect_pc = 16'h0031; stall = 1'b1;
    step();
    check("redir.addr", imem_addr, 16'h0030);
    check("redir.valid", 16'(ifid_valid), 16'h0000);
    check("redir.count", fetch_count, 16'd5);
    redirect_valid = 1'b0; stall = 1'b0;
    step();
    check_ifid("f30", 1'b1, 16'h4444, 16'h0030, 16'h0032);

    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    step();
    check("wrap.addr", imem_addr, 16'hFFFE);
    redirect_valid = 1'b0;
    step();
    check_ifid("wrap", 1'b1, 16'h3333, 16'hFFFE, 16'h0000);
    check("wrap.addr2", imem_addr, 16'h0000);
    check("wrap.count", fetch_count, 16'd7);

    stall = 1'b1;
    step();
    force dut.fetch_count_q = 16'hFFFF;
    #1;
    release dut.fetch_count_q;
    step();
    check("sat.hold", fetch_count, 16'hFFFF);
    stall = 1'b0;
    step();
    check("sat.fetch", fetch_count, 16'hFFFF);
    check_ifid("sat", 1'b1, 16'h1234, 16'h0000, 16'h0002);

    stall = 1'b1; rst = 1'b1;
    step();
    check_ifid("rst2", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    check("rst2.count", fetch_count, 16'h0000);
    check("rst2.addr", imem_addr, 16'h0000);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the single-cycle instruction memory (memory1c_instr).
- Owns the PC and drives the memory's address, enable and write controls.
- Consumes the combinational read data and latches instruction, PC and PC+2 into the IF/ID pipeline register.
- Handles stalls, branch redirects and HLT detection for the WISC 16-bit ISA.

Parameters:
- DWIDTH, 16, instruction width in bits.
- AWIDTH, 16, byte-address width of PC and imem address.
- RESET_PC, 16'h0000, PC value loaded on reset.
- HLT_OPCODE, 4'hF, value of instr[15:12] that identifies HLT.

Ports:
- clk  in  1  Single clock; all state updates on rising edge.
- rst  in  1  Synchronous, active-high reset.
- imem_addr  out  AWIDTH  Byte address to instruction memory; always equals PC; bit 0 is always 0.
- imem_enable  out  1  High when state==RUN and rst==0.
- imem_wr  out  1  Tied 0.
- imem_wdata  out  DWIDTH  Tied 0; drives memory data_in.
- imem_rdata  in  DWIDTH  Combinational read data from memory.
- stall  in  1  Hold PC and IF/ID contents.
- redirect_valid  in  1  Taken branch/jump from a later stage.
- redirect_pc  in  AWIDTH  Redirect target; bit 0 is ignored.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  DWIDTH  Latched instruction.
- ifid_pc  out  AWIDTH  Address of the latched instruction.
- ifid_pc_plus2  out  AWIDTH  ifid_pc + 2, modulo 2^AWIDTH.
- halted  out  1  state==HALTED.
- fetch_count  out  16  Count of instructions latched valid; saturating.

Behaviour:
- Reset values: PC=RESET_PC; state=RUN; ifid_valid=0; ifid_instr, ifid_pc, ifid_pc_plus2 = 0; fetch_count=0; halted=0.
- During rst, imem_enable=0. The memory loads its image in the reset cycle. The first fetch is at RESET_PC in the first cycle after rst falls.
- States: RUN, HALTED.
- Per-edge priority: rst > redirect_valid > stall > normal fetch.
- Redirect (any state):
  - PC <= {redirect_pc[AWIDTH-1:1],1'b0}.
  - ifid_valid <= 0 and ifid_instr <= 0 (bubble).
  - state <= RUN.
  - Redirect with stall high in the same cycle: redirect wins.
- Stall in RUN (no redirect): PC, IF/ID and state hold; fetch_count holds.
- Normal fetch in RUN:
  - ifid_instr <= imem_rdata; ifid_pc <= PC; ifid_pc_plus2 <= PC+2; ifid_valid <= 1; fetch_count increments.
  - If imem_rdata[15:12] != HLT_OPCODE: PC <= PC+2. Wrap-around: 16'hFFFE -> 16'h0000.
  - If imem_rdata[15:12] == HLT_OPCODE: PC holds at the HLT address and state <= HALTED.
- HALTED (no redirect):
  - imem_enable=0; PC holds.
  - If stall=0: ifid_valid <= 0 (HLT is issued exactly once). If stall=1: IF/ID holds.
  - Exit only via redirect (HLT fetched on a mispredicted path) or rst.
- Latency: an instruction at address A appears on IF/ID one edge after imem_addr==A with stall=0.
- After a redirect, the target instruction reaches IF/ID on the second edge: edge 1 loads the PC, edge 2 latches the instruction.
- fetch_count saturates at 16'hFFFF; it is not cleared by redirect.
- Reset mid-halt or mid-stall: full reset values apply on that edge.

Decomposition:
- Package wisc_pkg holds:
  - fetch state enum (RUN, HALTED);
  - OP_HLT = 4'hF;
  - ILEN_BYTES = 2;
  - DEFAULT_RESET_PC.
- One sub-module, ifid_reg: a load/hold/bubble register for valid, instr, pc and pc_plus2 with a synchronous reset.
- PC, FSM and counter stay in fetch_stage.

Test Plan:
- Reset then run: memory preloaded 0x0000:1234, 0x0002:5678, stall=0.
  - Edge 1 after reset: ifid=(1,1234,0000,0002).
  - Edge 2: ifid=(1,5678,0002,0004); fetch_count=2.
- Stall: assert stall for 3 cycles while ifid holds 5678.
  - IF/ID, PC (0x0004) and fetch_count are unchanged.
  - On release, the next edge latches mem[0x0004].
- Redirect over stall: redirect_valid=1, redirect_pc=0x0031, stall=1.
  - Next edge: PC=0x0030, ifid_valid=0.
  - Following edge: ifid_pc=0x0030.
- HLT: mem[0x0006]=F000.
  - ifid=(1,F000,0006,0008); halted=1; imem_enable=0.
  - Next unstalled edge: ifid_valid=0; PC stays 0x0006; count +1 only once.
- Halt then redirect: while HALTED, redirect_pc=0x0010.
  - halted=0; fetch resumes at 0x0010 with imem_enable=1.
- Wrap and saturation:
  - PC=0xFFFE with non-HLT word: next PC=0x0000 and ifid_pc_plus2=0x0000.
  - Force fetch_count to 0xFFFF: it stays 0xFFFF after another fetch.
